// File: rtl/lcd1602_capture.sv
// rtl/lcd1602_capture.sv - passive HD44780-style bus snooper keeping a 2x16 shadow of the display
module lcd1602_capture #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       char_valid,
    output logic       busy,
    output logic       init_done,
    output logic       err
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] rw_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [7:0]             data_sync [SYNC_STAGES];

    logic       rs_d;
    logic       rw_d;
    logic       en_d;
    logic [7:0] data_d;
    logic       fall;

    state_t     state_q;
    state_t     state_d;
    logic [4:0] clr_idx;
    logic       dir_inc;
    logic       addr_ok;
    logic       is_clear;
    logic [7:0] mem [32];

    // Flops reset to 0 so releasing reset with lcd_en high cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_sync <= '0;
            rw_sync <= '0;
            en_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
            rs_d    <= 1'b0;
            rw_d    <= 1'b0;
            en_d    <= 1'b0;
            data_d  <= 8'h00;
        end else begin
            rs_sync <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            rw_sync <= {rw_sync[SYNC_STAGES-2:0], lcd_rw};
            en_sync <= {en_sync[SYNC_STAGES-2:0], lcd_en};
            data_sync[0] <= lcd_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            rs_d    <= rs_sync[SYNC_STAGES-1];
            rw_d    <= rw_sync[SYNC_STAGES-1];
            en_d    <= en_sync[SYNC_STAGES-1];
            data_d  <= data_sync[SYNC_STAGES-1];
        end
    end

    // Bus fields are taken from the cycle before the edge, while en was still high.
    assign fall     = en_d & ~en_sync[SYNC_STAGES-1];
    assign is_clear = fall & ~rs_d & ~rw_d & (data_d == 8'h01);
    assign busy     = (state_q == ST_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (is_clear) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_idx == 5'd31) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= BLANK_CHAR;
            rd_data    <= BLANK_CHAR;
            cursor     <= 5'd0;
            dir_inc    <= 1'b1;
            addr_ok    <= 1'b1;
            clr_idx    <= 5'd0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 8'h00;
            char_valid <= 1'b0;
            init_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            rd_data    <= mem[rd_addr];

            if (busy) begin
                mem[clr_idx] <= BLANK_CHAR;
                clr_idx      <= clr_idx + 5'd1;
            end

            if (fall) begin
                if (busy || rw_d) begin
                    err <= 1'b1;
                end else if (!rs_d) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= data_d;
                    if (data_d == 8'h01) begin
                        cursor  <= 5'd0;
                        dir_inc <= 1'b1;
                        clr_idx <= 5'd0;
                    end else if (data_d[7:1] == 7'b0000001) begin
                        cursor <= 5'd0;
                    end else if (data_d[7:2] == 6'b000001) begin
                        dir_inc <= data_d[1];
                    end else if (data_d[7:4] == 4'h3) begin
                        init_done <= 1'b1;
                    end else if (data_d[7:4] == 4'h8 || data_d[7:4] == 4'hC) begin
                        cursor  <= {data_d[6], data_d[3:0]};
                        addr_ok <= 1'b1;
                    end else if (data_d[7]) begin
                        addr_ok <= 1'b0;
                    end
                end else if (addr_ok) begin
                    mem[cursor] <= data_d;
                    char_valid  <= 1'b1;
                    cursor      <= dir_inc ? cursor + 5'd1 : cursor - 5'd1;
                end
            end
        end
    end

endmodule

// File: doc/lcd1602_capture.md
LCD1602_CAPTURE -- requirements
Module: lcd1602_capture

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchroniser flops on every LCD bus input (legal values 2-3).
REQ-002 Parameter: BLANK_CHAR, default 8'h20, value written by reset and by the clear command.
REQ-003 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: lcd_rs  input  1  register select; 0 = command, 1 = data.
REQ-006 Port: lcd_rw  input  1  read/write; 0 = write, 1 = read.
REQ-007 Port: lcd_en  input  1  enable strobe; a transfer completes on its falling edge.
REQ-008 Port: lcd_data  input  8  bus data.
REQ-009 Port: rd_addr  input  5  shadow buffer read index; 0-15 is line 1, 16-31 is line 2.
REQ-010 Port: rd_data  output  8  shadow character at rd_addr, registered.
REQ-011 Port: cursor  output  5  current write index.
REQ-012 Port: cmd_valid  output  1  one-cycle pulse when a command is accepted.
REQ-013 Port: cmd_code  output  8  last accepted command byte.
REQ-014 Port: char_valid  output  1  one-cycle pulse when a character is written.
REQ-015 Port: busy  output  1  high while a clear is in progress.
REQ-016 Port: init_done  output  1  sticky; set by the first function-set command.
REQ-017 Port: err  output  1  sticky; set by a read strobe or by a strobe received while busy.

Function
REQ-018 lcd_rs, lcd_rw, lcd_en and lcd_data SHALL each pass through SYNC_STAGES flops; a falling edge is synchronised en going 1 -> 0.
REQ-019 On a falling edge, rs, rw and data SHALL be taken from the synchronised values of the previous cycle, while en was still high.
REQ-020 A decoded transfer SHALL take effect, and its pulse SHALL assert, exactly 1 cycle after the synchronised falling edge.
REQ-021 Command 8'h01 (clear) SHALL assert busy, set cursor = 0 and direction = increment, and write BLANK_CHAR to indices 0..31, one per cycle; busy SHALL deassert after the 32nd write.
REQ-022 Command 8'h02 or 8'h03 (home) SHALL set cursor = 0 and leave the buffer unchanged.
REQ-023 Commands 8'h04-8'h07 (entry mode) SHALL set direction from bit 1: 1 = increment, 0 = decrement.
REQ-024 Commands 8'h30-8'h3F (function set) SHALL set init_done.
REQ-025 Commands 8'h80-8'h8F SHALL set cursor = data[3:0]; 8'hC0-8'hCF SHALL set cursor = 16 + data[3:0]. Both SHALL set the internal addr_ok flag.
REQ-026 Any other 8'h80-8'hFF command SHALL clear addr_ok; data writes SHALL be dropped, with no char_valid, until addr_ok is set again.
REQ-027 Every remaining command byte SHALL be accepted with a cmd_valid pulse and no other effect.
REQ-028 A data write (rs = 1, rw = 0) with addr_ok set SHALL store the byte at buffer[cursor], pulse char_valid, and step cursor ±1 modulo 32 (31 -> 0 on increment, 0 -> 31 on decrement).
REQ-029 A read strobe (rw = 1) SHALL be ignored and SHALL set err.
REQ-030 Any strobe while busy SHALL be dropped and SHALL set err.
REQ-031 rd_data SHALL equal the buffer[rd_addr] contents of the previous cycle (1-cycle latency). A same-cycle write to that index SHALL be visible on the following cycle.

Reset
REQ-032 While rst_n = 0: all buffer entries = BLANK_CHAR, cursor = 0, direction = increment, addr_ok = 1, rd_data = BLANK_CHAR, cmd_code = 0, and all 1-bit outputs = 0.
REQ-033 Reset asserted mid-clear SHALL abort the clear immediately; after release, the block SHALL be idle with the buffer fully blank.
REQ-034 Synchroniser flops SHALL reset to 0, so that release with lcd_en high does not produce a falling edge.

Verification
REQ-035 Writes of 8'h38, 8'h80, then "HI" (8'h48, 8'h49) -> init_done = 1; rd_addr 0 returns 8'h48 and rd_addr 1 returns 8'h49; cursor = 2; two char_valid pulses.
REQ-036 Write 8'hC0 then 17 data bytes -> entries 16..31 and then entry 0 are written; cursor wraps to 1.
REQ-037 Write 8'h04, 8'h8F, then data 8'h41 -> entry 15 = 8'h41; cursor = 14.
REQ-038 Write 8'h01, then a data strobe 5 cycles later -> busy high for 32 cycles; the strobe is dropped; err = 1; all 32 entries read 8'h20.
REQ-039 Write 8'h90 then data 8'h5A -> no char_valid and the buffer is unchanged; then write 8'h81 and 8'h5A -> entry 1 = 8'h5A.
REQ-040 Apply a read strobe, then rst_n low for 1 cycle during a clear -> err = 1 before the reset; after release, err = 0, busy = 0, cursor = 0.
